// File: rtl/sigma_stream_if.sv
// sigma_stream_if: beat-input and packet-result valid/ready handshakes for sigma_stream
`ifndef N
`define N 16
`endif
interface sigma_stream_if #(
  parameter int W = `N,
  parameter int LANES = 8,
  parameter int BW = 9
);
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
  logic [LANES*W-1:0] in_data;
  logic [LANES-1:0] in_mask;
  logic [W-1:0] out_data;
  logic [BW-1:0] out_beats;
  modport master (output in_valid, in_data, in_mask, in_last, out_ready,
                  input in_ready, out_valid, out_data, out_sat, out_beats);
  modport slave (input in_valid, in_data, in_mask, in_last, out_ready,
                 output in_ready, out_valid, out_data, out_sat, out_beats);
endinterface

// File: rtl/sigma_stream.sv
// sigma_stream: per-packet saturated signed-magnitude sum of LANES operands per beat
`ifndef N
`define N 16
`endif
module sigma_stream #(
  parameter int W = `N,
  parameter int LANES = 8,
  parameter int PIPE = 1,
  parameter int MAXB = 256,
  localparam int BW = $clog2(MAXB + 1)
) (
  input logic clk,
  input logic rst_n,
  sigma_stream_if.slave s
);
  localparam int SW = W + $clog2(LANES) + 1;
  localparam int AW = SW + BW;
  localparam logic signed [AW-1:0] LIM = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  typedef enum logic [1:0] {ACC, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic fire, add_v, clear, done_go, hi, lo, ovf, ovf_n;
  logic signed [SW-1:0] bsum, add_sum;
  logic signed [AW-1:0] acc, acc_n;
  logic signed [AW:0] wide;
  logic [W-2:0] neg;
  logic [BW-1:0] beats, beats_n;
  assign fire = s.in_valid && s.in_ready;
  assign s.in_ready = rst_n && state == ACC;
  assign s.out_valid = state == DONE;
  assign clear = state == DONE && s.out_ready;
  assign done_go = state_n == DONE && state != DONE;
  // exact beat sum: lanes converted to two's complement, masked lanes and -0 add nothing
  always_comb begin
    bsum = '0;
    for (int i = 0; i < LANES; i++)
      if (s.in_mask[i])
        bsum = s.in_data[i*W+W-1] ? bsum - SW'(s.in_data[i*W +: W-1]) : bsum + SW'(s.in_data[i*W +: W-1]);
  end
  if (PIPE != 0) begin : g_pipe
    logic st_v;
    logic signed [SW-1:0] st_sum;
    // stage register holding the previous beat's tree sum
    always_ff @(posedge clk)
      if (!rst_n) begin
        st_v <= 1'b0;
        st_sum <= '0;
      end else begin
        st_v <= fire;
        st_sum <= bsum;
      end
    assign add_v = st_v;
    assign add_sum = st_sum;
  end else begin : g_comb
    assign add_v = fire;
    assign add_sum = bsum;
  end
  // next accumulator/count/flag, result range checks and FSM transitions
  always_comb begin
    wide = (AW+1)'(acc) + (AW+1)'(add_sum);
    acc_n = !add_v ? acc : wide[AW] != wide[AW-1] ? {wide[AW], {(AW-1){!wide[AW]}}} : wide[AW-1:0];
    beats_n = fire && beats != BW'(MAXB) ? beats + BW'(1) : beats;
    ovf_n = ovf || (fire && beats == BW'(MAXB));
    neg = (W-1)'(-acc_n);
    hi = acc_n > LIM;
    lo = acc_n < -LIM;
    state_n = state == ACC && fire && s.in_last ? (PIPE != 0 ? FLUSH : DONE) :
              state == FLUSH ? DONE : clear ? ACC : state;
  end
  // state, accumulation and registered result capture on entry to DONE
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ACC;
      acc <= '0;
      beats <= '0;
      ovf <= 1'b0;
      s.out_data <= '0;
      s.out_sat <= 1'b0;
      s.out_beats <= '0;
    end else begin
      state <= state_n;
      acc <= clear ? '0 : acc_n;
      beats <= clear ? '0 : beats_n;
      ovf <= clear ? 1'b0 : ovf_n;
      if (done_go) begin
        s.out_data <= hi ? {1'b0, {(W-1){1'b1}}} : lo ? {1'b1, {(W-1){1'b1}}} :
                      acc_n < 0 ? {1'b1, neg} : {1'b0, acc_n[W-2:0]};
        s.out_sat <= hi || lo || ovf_n;
        s.out_beats <= beats_n;
      end
    end
endmodule

// File: tb/tb_sigma_stream.sv
// tb_sigma_stream: random and directed packets on a PIPE=1/MAXB=256 and a PIPE=0/MAXB=4 instance vs a packet-level sum model
module tb_sigma_stream;
  logic clk = 0, rst_n = 0, sel = 0;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [127:0] in_data = '0;
  logic [7:0] in_mask = '0;
  int total = 0, bad = 0, cyc = 0;
  logic [127:0] pd[$];
  logic [7:0] pm[$];
  logic rdy, ov, os;
  logic [15:0] od;
  logic [8:0] ob;
  sigma_stream_if #(.W(16), .LANES(8), .BW(9)) a ();
  sigma_stream_if #(.W(16), .LANES(8), .BW(3)) b ();
  assign a.in_valid = in_valid && !sel;
  assign b.in_valid = in_valid && sel;
  assign a.out_ready = out_ready && !sel;
  assign b.out_ready = out_ready && sel;
  assign a.in_data = in_data;
  assign b.in_data = in_data;
  assign a.in_mask = in_mask;
  assign b.in_mask = in_mask;
  assign a.in_last = in_last;
  assign b.in_last = in_last;
  assign rdy = sel ? b.in_ready : a.in_ready;
  assign ov = sel ? b.out_valid : a.out_valid;
  assign os = sel ? b.out_sat : a.out_sat;
  assign od = sel ? b.out_data : a.out_data;
  assign ob = sel ? 9'(b.out_beats) : a.out_beats;
  sigma_stream #(.W(16), .LANES(8), .PIPE(1), .MAXB(256)) u_p1 (.clk(clk), .rst_n(rst_n), .s(a));
  sigma_stream #(.W(16), .LANES(8), .PIPE(0), .MAXB(4)) u_p0 (.clk(clk), .rst_n(rst_n), .s(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(output logic [15:0] d, output logic s, output int nb);
    longint sum = 0;
    int n = pd.size(), maxb = sel ? 4 : 256;
    logic [15:0] v;
    foreach (pd[k])
      for (int i = 0; i < 8; i++) begin
        v = pd[k][i*16 +: 16];
        if (pm[k][i]) sum += v[15] ? -longint'(v[14:0]) : longint'(v[14:0]);
      end
    s = n > maxb || sum > 32767 || sum < -32767;
    nb = n > maxb ? maxb : n;
    d = sum > 32767 ? 16'h7fff : sum < -32767 ? 16'hffff : sum < 0 ? {1'b1, 15'(-sum)} : 16'(sum);
  endfunction
  function automatic logic [127:0] rnd(input logic big);
    logic [127:0] r;
    for (int i = 0; i < 8; i++)
      r[i*16 +: 16] = big ? 16'($urandom) : {1'($urandom), 15'($urandom_range(0, 800))};
    return r;
  endfunction
  task automatic beat(input logic [127:0] d, input logic [7:0] m, input logic l, input logic gap, output int t0);
    int n = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1;
    in_data = d;
    in_mask = m;
    in_last = l;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) chk("in_ready_timeout", rdy, 1);
    t0 = cyc;
    @(posedge clk);
    #1 in_valid = 0;
    in_last = 0;
  endtask
  task automatic collect(input logic [15:0] ed, input logic es, input int eb, input int t0, input int stall);
    int n = 0;
    @(negedge clk);
    while (!ov && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid", ov, 1);
    chk("latency", cyc - t0, sel ? 1 : 2);
    chk("out_data", od, ed);
    chk("out_sat", os, es);
    chk("out_beats", ob, eb);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", ov, 1);
      chk("hold_data", od, ed);
      chk("hold_sat", os, es);
      chk("hold_ready", rdy, 0);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("next_ready", rdy, 1);
    chk("valid_cleared", ov, 0);
  endtask
  task automatic run_pkt(input int stall, input logic gap);
    logic [15:0] ed;
    logic es;
    int eb, t0;
    model(ed, es, eb);
    foreach (pd[k]) beat(pd[k], pm[k], k == pd.size() - 1, gap, t0);
    collect(ed, es, eb, t0, stall);
    pd.delete();
    pm.delete();
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int t0, n;
    repeat (3) @(negedge clk);
    chk("reset_valid", ov, 0);
    chk("reset_data", od, 0);
    chk("reset_sat", os, 0);
    chk("reset_beats", ob, 0);
    chk("reset_ready", rdy, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", rdy, 1);
    pd.push_back({16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
    pm.push_back(8'hff);
    run_pkt(0, 0);
    pd.push_back({80'h0, 16'h8000, 16'h8005, 16'h0005});
    pm.push_back(8'hff);
    run_pkt(0, 0);
    repeat (3) begin pd.push_back({8{16'h1000}}); pm.push_back(8'hff); end
    run_pkt(0, 0);
    repeat (3) begin pd.push_back({8{16'h9000}}); pm.push_back(8'hff); end
    run_pkt(0, 0);
    pd.push_back({8{16'h0002}});
    pm.push_back(8'h0f);
    run_pkt(0, 0);
    repeat (4) begin pd.push_back({8{16'h0002}}); pm.push_back(8'hff); end
    run_pkt(5, 1);
    pd.push_back({8{16'h0003}});
    pm.push_back(8'h00);
    run_pkt(0, 0);
    beat({8{16'h0100}}, 8'hff, 0, 0, t0);
    beat({8{16'h0100}}, 8'hff, 0, 0, t0);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (6) begin @(negedge clk); n += ov; end
    chk("no_valid_after_reset", n, 0);
    pd.push_back({8{16'h0001}});
    pm.push_back(8'hff);
    run_pkt(0, 0);
    sel = 1;
    repeat (5) begin pd.push_back(rnd(0)); pm.push_back(8'($urandom)); end
    run_pkt(1, 0);
    pd.push_back({8{16'h0001}});
    pm.push_back(8'hff);
    run_pkt(0, 0);
    for (int p = 0; p < 40; p++) begin
      sel = 1'($urandom);
      n = $urandom_range(1, sel ? 6 : 5);
      for (int k = 0; k < n; k++) begin
        pd.push_back(rnd($urandom_range(0, 3) == 0));
        pm.push_back(8'($urandom));
      end
      run_pkt($urandom_range(0, 2), 1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
